// File: rtl/ex_mem_pipe_pkg.sv
// Shared widths and the execute-to-memory bundle layout for the EX/MEM pipeline register.
package ex_mem_pipe_pkg;

   localparam int DATA_W     = 32;
   localparam int REG_ADDR_W = 5;
   localparam int PC_W       = 32;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] wd;
      logic                  wreg;
      logic [DATA_W-1:0]     wdata;
      logic                  inst_valid;
      logic [PC_W-1:0]       inst_pc;
   } ex_mem_bundle_t;

   localparam int BUNDLE_W = $bits(ex_mem_bundle_t);

endpackage

// File: rtl/pipe_skid_buf.sv
// Two-entry skid buffer: a main slot driving the output and one skid slot, with a
// registered upstream ready so no combinational path runs from i_out_ready to o_in_ready.
module pipe_skid_buf #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_flush,
   input  logic         i_in_valid,
   output logic         o_in_ready,
   input  logic [W-1:0] i_in_data,
   output logic         o_out_valid,
   input  logic         i_out_ready,
   output logic [W-1:0] o_out_data
);

   // Handshake: a beat transfers on any edge where valid & ready are both 1.
   // Once valid is raised with data, data stays stable until the transfer.
   logic         r_main_valid;
   logic         r_skid_valid;
   logic         r_in_ready;
   logic [W-1:0] r_main_data;
   logic [W-1:0] r_skid_data;

   logic w_accept;
   logic w_fire;
   logic w_main_free;

   assign w_accept    = i_in_valid & r_in_ready;
   assign w_fire      = r_main_valid & i_out_ready;
   assign w_main_free = ~r_main_valid | w_fire;

   assign o_in_ready  = r_in_ready;
   assign o_out_valid = r_main_valid;
   assign o_out_data  = r_main_data;

   // r_in_ready always tracks the complement of the next skid valid bit.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_main_valid <= 1'b0;
         r_skid_valid <= 1'b0;
         r_in_ready   <= 1'b1;
         r_main_data  <= '0;
         r_skid_data  <= '0;
      end else if (i_flush) begin
         r_main_valid <= 1'b0;
         r_skid_valid <= 1'b0;
         r_in_ready   <= 1'b1;
      end else if (w_main_free) begin
         if (r_skid_valid) begin
            r_main_data  <= r_skid_data;
            r_main_valid <= 1'b1;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
         end else if (w_accept) begin
            r_main_data  <= i_in_data;
            r_main_valid <= 1'b1;
         end else begin
            r_main_valid <= 1'b0;
         end
      end else if (w_accept) begin
         r_skid_data  <= i_in_data;
         r_skid_valid <= 1'b1;
         r_in_ready   <= 1'b0;
      end
   end

endmodule

// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline register with valid/ready handshake and flush.
// Define EX_MEM_PERF_CNT_EN to add stall/pass performance counters.
module ex_mem_pipe #(
   parameter int DATA_W     = ex_mem_pipe_pkg::DATA_W,
   parameter int REG_ADDR_W = ex_mem_pipe_pkg::REG_ADDR_W,
   parameter int PC_W       = ex_mem_pipe_pkg::PC_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ex_valid_i,
   output logic                  ex_ready_o,
   input  logic [REG_ADDR_W-1:0] ex_wd_i,
   input  logic                  ex_wreg_i,
   input  logic [DATA_W-1:0]     ex_wdata_i,
   input  logic                  ex_inst_valid_i,
   input  logic [PC_W-1:0]       ex_inst_pc_i,
   input  logic                  flush_i,
   output logic                  mem_valid_o,
   input  logic                  mem_ready_i,
   output logic [REG_ADDR_W-1:0] mem_wd_o,
   output logic                  mem_wreg_o,
   output logic [DATA_W-1:0]     mem_wdata_o,
   output logic                  mem_inst_valid_o,
   output logic [PC_W-1:0]       mem_inst_pc_o
`ifdef EX_MEM_PERF_CNT_EN
   ,
   output logic [31:0]           stall_cnt_o,
   output logic [31:0]           pass_cnt_o
`endif
);

   // Field order matches ex_mem_bundle_t: {wd, wreg, wdata, inst_valid, inst_pc}.
   localparam int BW      = REG_ADDR_W + 1 + DATA_W + 1 + PC_W;
   localparam int IV_BIT  = PC_W;
   localparam int WD_LSB  = PC_W + 1;
   localparam int WRG_BIT = PC_W + 1 + DATA_W;

   logic [BW-1:0] w_in_bundle;
   logic [BW-1:0] w_out_bundle;
   logic          w_out_valid;

   assign w_in_bundle = {ex_wd_i, ex_wreg_i, ex_wdata_i, ex_inst_valid_i, ex_inst_pc_i};

   pipe_skid_buf #(.W(BW)) u_skid (
      .clk         (clk),
      .rst         (rst),
      .i_flush     (flush_i),
      .i_in_valid  (ex_valid_i),
      .o_in_ready  (ex_ready_o),
      .i_in_data   (w_in_bundle),
      .o_out_valid (w_out_valid),
      .i_out_ready (mem_ready_i),
      .o_out_data  (w_out_bundle)
   );

   assign mem_valid_o      = w_out_valid;
   assign mem_wd_o         = w_out_bundle[BW-1 -: REG_ADDR_W];
   // Stale payload must never cause a register write downstream.
   assign mem_wreg_o       = w_out_valid & w_out_bundle[WRG_BIT];
   assign mem_wdata_o      = w_out_bundle[WD_LSB +: DATA_W];
   assign mem_inst_valid_o = w_out_bundle[IV_BIT];
   assign mem_inst_pc_o    = w_out_bundle[PC_W-1:0];

`ifdef EX_MEM_PERF_CNT_EN
   logic [31:0] r_stall_cnt;
   logic [31:0] r_pass_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_stall_cnt <= '0;
         r_pass_cnt  <= '0;
      end else begin
         if (w_out_valid & ~mem_ready_i) r_stall_cnt <= r_stall_cnt + 32'd1;
         if (w_out_valid & mem_ready_i)  r_pass_cnt  <= r_pass_cnt + 32'd1;
      end
   end

   assign stall_cnt_o = r_stall_cnt;
   assign pass_cnt_o  = r_pass_cnt;
`endif

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Directed self-checking bench for ex_mem_pipe; counter checks are compiled in with EX_MEM_PERF_CNT_EN.
module tb_ex_mem_pipe;
   import ex_mem_pipe_pkg::*;

   logic                  clk = 1'b0;
   logic                  rst = 1'b0;
   logic                  ex_valid_i = 1'b0;
   logic                  ex_ready_o;
   logic [REG_ADDR_W-1:0] ex_wd_i = '0;
   logic                  ex_wreg_i = 1'b0;
   logic [DATA_W-1:0]     ex_wdata_i = '0;
   logic                  ex_inst_valid_i = 1'b0;
   logic [PC_W-1:0]       ex_inst_pc_i = '0;
   logic                  flush_i = 1'b0;
   logic                  mem_valid_o;
   logic                  mem_ready_i = 1'b0;
   logic [REG_ADDR_W-1:0] mem_wd_o;
   logic                  mem_wreg_o;
   logic [DATA_W-1:0]     mem_wdata_o;
   logic                  mem_inst_valid_o;
   logic [PC_W-1:0]       mem_inst_pc_o;
`ifdef EX_MEM_PERF_CNT_EN
   logic [31:0]           stall_cnt_o;
   logic [31:0]           pass_cnt_o;
`endif

   int errors = 0;
   int checks = 0;

   ex_mem_pipe dut (
      .clk              (clk),
      .rst              (rst),
      .ex_valid_i       (ex_valid_i),
      .ex_ready_o       (ex_ready_o),
      .ex_wd_i          (ex_wd_i),
      .ex_wreg_i        (ex_wreg_i),
      .ex_wdata_i       (ex_wdata_i),
      .ex_inst_valid_i  (ex_inst_valid_i),
      .ex_inst_pc_i     (ex_inst_pc_i),
      .flush_i          (flush_i),
      .mem_valid_o      (mem_valid_o),
      .mem_ready_i      (mem_ready_i),
      .mem_wd_o         (mem_wd_o),
      .mem_wreg_o       (mem_wreg_o),
      .mem_wdata_o      (mem_wdata_o),
      .mem_inst_valid_o (mem_inst_valid_o),
      .mem_inst_pc_o    (mem_inst_pc_o)
`ifdef EX_MEM_PERF_CNT_EN
      ,
      .stall_cnt_o      (stall_cnt_o),
      .pass_cnt_o       (pass_cnt_o)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Inputs change and outputs are sampled 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic v, input ex_mem_bundle_t b);
      ex_valid_i      = v;
      ex_wd_i         = b.wd;
      ex_wreg_i       = b.wreg;
      ex_wdata_i      = b.wdata;
      ex_inst_valid_i = b.inst_valid;
      ex_inst_pc_i    = b.inst_pc;
   endtask

   function automatic ex_mem_bundle_t mk(input logic [4:0] wd, input logic [31:0] wdata,
                                         input logic [31:0] pc);
      ex_mem_bundle_t b;
      b.wd = wd; b.wreg = 1'b1; b.wdata = wdata; b.inst_valid = 1'b1; b.inst_pc = pc;
      return b;
   endfunction

   task automatic do_reset();
      offer(1'b0, '0);
      flush_i = 1'b0; mem_ready_i = 1'b0;
      rst = 1'b0;
      tick(); tick();
      rst = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b0;
      tick();
      checks++; if (ex_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ex_ready_o); end
      checks++; if (mem_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", mem_valid_o); end
      checks++;
      if ({mem_wd_o, mem_wreg_o, mem_wdata_o, mem_inst_valid_o, mem_inst_pc_o} !== '0) begin
         errors++; $display("FAIL reset_payload: got wd=%h wreg=%b wdata=%h iv=%b pc=%h want all 0",
                            mem_wd_o, mem_wreg_o, mem_wdata_o, mem_inst_valid_o, mem_inst_pc_o);
      end
      rst = 1'b1;
      tick();
   endtask

   task automatic test_single();
      ex_mem_bundle_t a;
      a = mk(5'd5, 32'h0000_1234, 32'h0000_0100);
      mem_ready_i = 1'b1;
      offer(1'b1, a);
      checks++; if (ex_ready_o !== 1'b1) begin errors++; $display("FAIL single_ready_pre: got %b want 1", ex_ready_o); end
      tick();
      offer(1'b0, '0);
      checks++; if (mem_valid_o !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", mem_valid_o); end
      checks++; if (mem_wd_o !== a.wd) begin errors++; $display("FAIL single_wd: got %h want %h", mem_wd_o, a.wd); end
      checks++; if (mem_wdata_o !== a.wdata) begin errors++; $display("FAIL single_wdata: got %h want %h", mem_wdata_o, a.wdata); end
      checks++; if (mem_wreg_o !== 1'b1) begin errors++; $display("FAIL single_wreg: got %b want 1", mem_wreg_o); end
      checks++; if (ex_ready_o !== 1'b1) begin errors++; $display("FAIL single_ready: got %b want 1", ex_ready_o); end
      tick();
      checks++; if (mem_valid_o !== 1'b0) begin errors++; $display("FAIL single_drain: got %b want 0", mem_valid_o); end
      checks++; if (mem_wreg_o !== 1'b0) begin errors++; $display("FAIL single_wreg_gate: got %b want 0", mem_wreg_o); end
   endtask

   task automatic test_back_to_back();
      ex_mem_bundle_t b;
      mem_ready_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         b = mk(5'(i + 1), 32'hA000_0000 + 32'(i), 32'h1c00_0000 + 32'(4 * i));
         offer(1'b1, b);
         tick();
         checks++;
         if (mem_valid_o !== 1'b1 || mem_inst_pc_o !== b.inst_pc || mem_wdata_o !== b.wdata || ex_ready_o !== 1'b1) begin
            errors++; $display("FAIL b2b_%0d: got v=%b pc=%h data=%h rdy=%b want v=1 pc=%h data=%h rdy=1",
                               i, mem_valid_o, mem_inst_pc_o, mem_wdata_o, ex_ready_o, b.inst_pc, b.wdata);
         end
      end
      offer(1'b0, '0);
      tick();
      checks++; if (mem_valid_o !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b want 0", mem_valid_o); end
   endtask

   task automatic test_backpressure();
      ex_mem_bundle_t a, b, c;
      a = mk(5'd7, 32'hAAAA_0001, 32'h0000_2000);
      b = mk(5'd9, 32'hBBBB_0002, 32'h0000_2004);
      c = mk(5'd11, 32'hCCCC_0003, 32'h0000_2008);
      mem_ready_i = 1'b0;
      offer(1'b1, a);
      tick();
      checks++; if (mem_inst_pc_o !== a.inst_pc || ex_ready_o !== 1'b1) begin
         errors++; $display("FAIL bp_load_a: got pc=%h rdy=%b want pc=%h rdy=1", mem_inst_pc_o, ex_ready_o, a.inst_pc); end
      offer(1'b1, b);
      tick();
      checks++; if (ex_ready_o !== 1'b0) begin errors++; $display("FAIL bp_ready_low: got %b want 0", ex_ready_o); end
      offer(1'b1, c);
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (mem_valid_o !== 1'b1 || mem_wd_o !== a.wd || mem_wdata_o !== a.wdata || mem_inst_pc_o !== a.inst_pc ||
             mem_wreg_o !== 1'b1 || mem_inst_valid_o !== 1'b1) begin
            errors++; $display("FAIL bp_hold_%0d: got v=%b wd=%h data=%h pc=%h want v=1 wd=%h data=%h pc=%h",
                               i, mem_valid_o, mem_wd_o, mem_wdata_o, mem_inst_pc_o, a.wd, a.wdata, a.inst_pc);
         end
         tick();
      end
      offer(1'b0, '0);
      mem_ready_i = 1'b1;
      checks++; if (mem_inst_pc_o !== a.inst_pc) begin errors++; $display("FAIL bp_a_out: got %h want %h", mem_inst_pc_o, a.inst_pc); end
      tick();
      checks++; if (mem_valid_o !== 1'b1 || mem_inst_pc_o !== b.inst_pc || mem_wd_o !== b.wd) begin
         errors++; $display("FAIL bp_b_out: got v=%b pc=%h wd=%h want v=1 pc=%h wd=%h", mem_valid_o, mem_inst_pc_o, mem_wd_o, b.inst_pc, b.wd); end
      checks++; if (ex_ready_o !== 1'b1) begin errors++; $display("FAIL bp_ready_back: got %b want 1", ex_ready_o); end
      tick();
      checks++; if (mem_valid_o !== 1'b0) begin errors++; $display("FAIL bp_no_c: got v=%b pc=%h want v=0", mem_valid_o, mem_inst_pc_o); end
   endtask

   task automatic test_flush();
      ex_mem_bundle_t a, b, d;
      a = mk(5'd1, 32'h1111_1111, 32'h0000_3000);
      b = mk(5'd2, 32'h2222_2222, 32'h0000_3004);
      d = mk(5'd3, 32'hDDDD_DDDD, 32'h0000_3008);
      mem_ready_i = 1'b0;
      offer(1'b1, a); tick();
      offer(1'b1, b); tick();
      offer(1'b1, d); flush_i = 1'b1;
      tick();
      flush_i = 1'b0; offer(1'b0, '0);
      checks++; if (mem_valid_o !== 1'b0 || mem_wreg_o !== 1'b0) begin
         errors++; $display("FAIL flush_full_valid: got v=%b wreg=%b want 0 0", mem_valid_o, mem_wreg_o); end
      checks++; if (ex_ready_o !== 1'b1) begin errors++; $display("FAIL flush_full_ready: got %b want 1", ex_ready_o); end
      mem_ready_i = 1'b1;
      tick();
      checks++; if (mem_valid_o !== 1'b0) begin errors++; $display("FAIL flush_full_ghost: got v=%b pc=%h want v=0", mem_valid_o, mem_inst_pc_o); end
      // Flush while the input would otherwise be accepted into an empty skid slot.
      mem_ready_i = 1'b0;
      offer(1'b1, a); tick();
      offer(1'b1, d); flush_i = 1'b1;
      tick();
      flush_i = 1'b0; offer(1'b0, '0); mem_ready_i = 1'b1;
      checks++; if (mem_valid_o !== 1'b0 || ex_ready_o !== 1'b1) begin
         errors++; $display("FAIL flush_accept: got v=%b rdy=%b want v=0 rdy=1", mem_valid_o, ex_ready_o); end
      tick();
      checks++; if (mem_valid_o !== 1'b0) begin errors++; $display("FAIL flush_accept_ghost: got %b want 0", mem_valid_o); end
   endtask

   task automatic test_async_reset();
      ex_mem_bundle_t a, b;
      a = mk(5'd4, 32'h4444_4444, 32'h0000_4000);
      b = mk(5'd6, 32'h6666_6666, 32'h0000_4004);
      mem_ready_i = 1'b0;
      offer(1'b1, a); tick();
      offer(1'b1, b); tick();
      offer(1'b0, '0);
      checks++; if (mem_valid_o !== 1'b1 || ex_ready_o !== 1'b0) begin
         errors++; $display("FAIL arst_pre: got v=%b rdy=%b want v=1 rdy=0", mem_valid_o, ex_ready_o); end
      #2 rst = 1'b0;
      #1;
      checks++; if (mem_valid_o !== 1'b0 || mem_wreg_o !== 1'b0) begin
         errors++; $display("FAIL arst_valid: got v=%b wreg=%b want 0 0", mem_valid_o, mem_wreg_o); end
      checks++; if (ex_ready_o !== 1'b1) begin errors++; $display("FAIL arst_ready: got %b want 1", ex_ready_o); end
      checks++; if (mem_inst_pc_o !== '0 || mem_wdata_o !== '0) begin
         errors++; $display("FAIL arst_payload: got pc=%h data=%h want 0 0", mem_inst_pc_o, mem_wdata_o); end
      tick();
      rst = 1'b1;
      tick();
   endtask

`ifdef EX_MEM_PERF_CNT_EN
   task automatic test_perf_cnt();
      do_reset();
      checks++; if (stall_cnt_o !== 32'd0 || pass_cnt_o !== 32'd0) begin
         errors++; $display("FAIL perf_reset: got stall=%0d pass=%0d want 0 0", stall_cnt_o, pass_cnt_o); end
      mem_ready_i = 1'b0;
      offer(1'b1, mk(5'd1, 32'h1, 32'h5000)); tick();
      offer(1'b1, mk(5'd2, 32'h2, 32'h5004)); tick();
      offer(1'b0, '0);
      tick(); tick();
      mem_ready_i = 1'b1;
      tick(); tick();
      mem_ready_i = 1'b0;
      checks++; if (stall_cnt_o !== 32'd3) begin errors++; $display("FAIL perf_stall: got %0d want 3", stall_cnt_o); end
      checks++; if (pass_cnt_o !== 32'd2) begin errors++; $display("FAIL perf_pass: got %0d want 2", pass_cnt_o); end
      flush_i = 1'b1; tick(); flush_i = 1'b0;
      checks++; if (stall_cnt_o !== 32'd3 || pass_cnt_o !== 32'd2) begin
         errors++; $display("FAIL perf_flush: got stall=%0d pass=%0d want 3 2", stall_cnt_o, pass_cnt_o); end
   endtask
`endif

   initial begin
      tick();
      test_reset();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_flush();
      test_async_reset();
`ifdef EX_MEM_PERF_CNT_EN
      test_perf_cnt();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ex_mem_pipe.md
Name: ex_mem_pipe

Overview:
- Pipeline register between the execute stage and the memory-access stage.
- Captures the execute-stage result bundle: destination register, write-enable, result data, instruction-valid flag and PC.
- Presents the bundle to the memory stage through a valid/ready handshake.
- A 2-entry skid buffer keeps throughput at 1 instruction/cycle with a fully registered upstream ready; a flush input squashes in-flight entries.

Parameters:
- DATA_W, 32, width of result data
- REG_ADDR_W, 5, width of destination register address
- PC_W, 32, width of instruction PC

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset asserted)
- ex_valid_i  in  1  execute stage offers a bundle
- ex_ready_o  out  1  block can accept a bundle; registered
- ex_wd_i  in  REG_ADDR_W  destination register address
- ex_wreg_i  in  1  register write enable
- ex_wdata_i  in  DATA_W  result data
- ex_inst_valid_i  in  1  instruction-valid flag
- ex_inst_pc_i  in  PC_W  instruction PC
- flush_i  in  1  squash all held entries
- mem_valid_o  out  1  bundle available to the memory stage
- mem_ready_i  in  1  memory stage accepts
- mem_wd_o  out  REG_ADDR_W  destination register address
- mem_wreg_o  out  1  write enable, forced 0 when mem_valid_o=0
- mem_wdata_o  out  DATA_W  result data
- mem_inst_valid_o  out  1  instruction-valid flag
- mem_inst_pc_o  out  PC_W  instruction PC

Behaviour:
- Storage: main slot (drives mem_*) plus one skid slot, each with its own valid bit.
- Reset (rst=0, asynchronous): both valid bits 0, all payload registers 0, ex_ready_o=1, mem_valid_o=0, all mem_* outputs 0.
- Accept: ex_valid_i & ex_ready_o. Fire: mem_valid_o & mem_ready_i.
- ex_ready_o = !skid_valid, registered. There is no combinational path from mem_ready_i to ex_ready_o.
- Main slot empty, or main slot firing:
  - If the skid slot is valid, its contents move to main and skid_valid clears.
  - Otherwise, an accepted input loads main.
  - Otherwise, main_valid clears.
- Main slot full and not firing: an accepted input loads the skid slot.
- Because ex_ready_o=0 whenever skid_valid=1, no input is accepted while the skid slot is occupied, so neither slot can overflow.
- Ordering is strictly FIFO.
- Latency: an accepted bundle appears on mem_* the cycle after acceptance when the path is unblocked.
- Sustained throughput: 1 bundle/cycle while mem_ready_i=1.
- Hold rule: while mem_valid_o=1 and mem_ready_i=0, every mem_* output stays bit-stable.
- Flush: flush_i=1 at a clock edge clears both valid bits and discards that cycle's input even if accepted.
  - Flush has priority over accept and fire.
  - Payload registers may retain stale values.
  - ex_ready_o=1 on the next cycle.
- Simultaneous accept and fire with an empty skid slot: main reloads from the input; skid stays empty.
- rst asserted mid-transfer drops all entries immediately, without waiting for a clock edge.

Optional Feature:
- Macro: EX_MEM_PERF_CNT_EN.
- When defined, two extra outputs exist:
  - stall_cnt_o, 32 bits: counts cycles with mem_valid_o=1 & mem_ready_i=0.
  - pass_cnt_o, 32 bits: counts fires.
  - Both wrap modulo 2^32, reset to 0 on rst, and are unaffected by flush_i.
- When undefined, these ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - width constants DATA_W, REG_ADDR_W, PC_W;
  - a packed bundle type ex_mem_bundle_t {wd, wreg, wdata, inst_valid, inst_pc}.
- One natural sub-module: pipe_skid_buf.
  - Generic over payload width; contains the two slots and the handshake logic.
  - ex_mem_pipe instantiates it and adds wreg gating, flush wiring and the optional counters.

Test Plan:
1. Reset release, then ex_valid_i=1, wd=5, wdata=0x1234 with mem_ready_i=1.
   - Next cycle: mem_valid_o=1, mem_wd_o=5, mem_wdata_o=0x1234.
   - ex_ready_o stays 1 throughout.
2. Back-to-back stream of PCs 0x1c000000, +4, +8, +12 with mem_ready_i=1.
   - Four consecutive fires in order; no bubble.
3. mem_ready_i=0 while two bundles A, B are offered.
   - A is held stable on mem_*; B goes to the skid slot; ex_ready_o=0 the following cycle.
   - Raise mem_ready_i: A, then B, exit on consecutive cycles; ex_ready_o returns to 1.
4. Both slots full, flush_i=1 asserted together with ex_valid_i=1.
   - Next cycle: mem_valid_o=0, ex_ready_o=1, and the flushed-cycle input never appears.
5. rst driven low between clock edges while mem_valid_o=1.
   - mem_valid_o and mem_wreg_o fall to 0 immediately; ex_ready_o becomes 1.
6. With EX_MEM_PERF_CNT_EN defined: 3 stalled cycles, then 2 fires.
   - stall_cnt_o=3 and pass_cnt_o=2; after a flush both are unchanged.
